unidade_controle: RTL and testbench

//  Multi-cycle controller feeding the 16x16 register bank. Accepts one 16-bit instruction per

---
 rtl/controle_pkg.sv | 54 +++++
 rtl/unidade_controle_ula.sv | 49 ++++
 rtl/unidade_controle.sv | 128 ++++++++++++
 tb/tb_unidade_controle.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// Shared definitions for the register-bank controller: datapath widths,
// opcode values, FSM state encoding and the instruction word layout.
//   Instruction word: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4.
//   LOAD reuses [7:0] as an 8-bit immediate.
package controle_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned INSTR_W = 16;

    // Instruction field bit positions
    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned RD_LSB   = 8;
    localparam int unsigned RS1_LSB  = 4;
    localparam int unsigned RS2_LSB  = 0;
    localparam int unsigned IMM8_LSB = 0;
    localparam int unsigned IMM8_W   = 8;

    // Opcodes
    localparam logic [OP_W-1:0] OP_LOAD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0011;
    localparam logic [OP_W-1:0] OP_SUBI  = 4'b0100;
    localparam logic [OP_W-1:0] OP_MUL   = 4'b0101;
    localparam logic [OP_W-1:0] OP_AND   = 4'b0110;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0111;
    localparam logic [OP_W-1:0] OP_XOR   = 4'b1000;
    localparam logic [OP_W-1:0] OP_NOT   = 4'b1001;
    localparam logic [OP_W-1:0] OP_SLL   = 4'b1010;
    localparam logic [OP_W-1:0] OP_SRL   = 4'b1011;
    localparam logic [OP_W-1:0] OP_CLEAR = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
    } instr_t;

    // LOAD immediate spans the rs1/rs2 fields
    function automatic logic [IMM8_W-1:0] instr_imm8(input instr_t i);
        return {i.rs1, i.rs2};
    endfunction

endpackage

// File: rtl/unidade_controle_ula.sv
// ula: combinational ALU for the controller.
//   op       opcode of the latched instruction
//   a, b     operands (bank read data A / B)
//   imm8     low byte of the instruction; imm4 is its low nibble
//   result_c result, modulo 2^DATA_W
//   illegal_c high when op selects no operation in the current configuration
// Build option: CTRL_MUL_EN enables the multiplier for opcode 0101; without it
// 0101 is reported illegal and no multiplier is built.
module ula
    import controle_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM8_W-1:0] imm8,
    output logic [DATA_W-1:0] result_c,
    output logic              illegal_c
);

    logic [3:0] imm4;
    assign imm4 = imm8[3:0];

    // Operation select; all arithmetic wraps at the datapath width
    always_comb begin
        result_c  = '0;
        illegal_c = 1'b0;
        case (op)
            OP_LOAD:  result_c = DATA_W'(imm8);
            OP_ADD:   result_c = a + b;
            OP_ADDI:  result_c = a + DATA_W'(imm4);
            OP_SUB:   result_c = a - b;
            OP_SUBI:  result_c = a - DATA_W'(imm4);
`ifdef CTRL_MUL_EN
            OP_MUL:   result_c = a * b;
`else
            OP_MUL:   illegal_c = 1'b1;
`endif
            OP_AND:   result_c = a & b;
            OP_OR:    result_c = a | b;
            OP_XOR:   result_c = a ^ b;
            OP_NOT:   result_c = ~a;
            OP_SLL:   result_c = a << imm4;
            OP_SRL:   result_c = a >> imm4;
            OP_CLEAR: result_c = '0;
            default:  illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle controller for a 16x16 register bank.
// Accepts one instruction per valid/ready handshake, walks
// IDLE -> DECODE -> EXEC -> WRITE -> IDLE, computes in the ula sub-module and
// writes the result back through the bank's write port.
//   instr_valid/instr/instr_ready   instruction handshake (ready only in IDLE)
//   endereco_reg1/2, conteudo_reg1/2 bank async read ports (rs1, rs2)
//   endereco_escrita/conteudo_escrita/enable  bank write port
//   ativar_clear   one-cycle bank clear pulse (CLEAR op)
//   done           one-cycle retirement pulse, also for illegal ops
//   erro           sticky illegal-opcode flag, cleared only by reset
// Build option: CTRL_MUL_EN (see ula) enables the MUL opcode.
module unidade_controle
    import controle_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] endereco_reg1,
    output logic [ADDR_W-1:0] endereco_reg2,
    input  logic [DATA_W-1:0] conteudo_reg1,
    input  logic [DATA_W-1:0] conteudo_reg2,
    output logic [ADDR_W-1:0] endereco_escrita,
    output logic [DATA_W-1:0] conteudo_escrita,
    output logic              enable,
    output logic              ativar_clear,
    output logic              done,
    output logic              erro
);

    state_t              state_q, state_d;
    instr_t              instr_q, instr_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                ready_q, ready_d;
    logic                enable_q, enable_d;
    logic                clear_q, clear_d;
    logic                done_q, done_d;
    logic                erro_q, erro_d;

    logic [DATA_W-1:0]   alu_result_c;
    logic                alu_illegal_c;

    ula u_ula (
        .op        (instr_q.op),
        .a         (conteudo_reg1),
        .b         (conteudo_reg2),
        .imm8      (instr_imm8(instr_q)),
        .result_c  (alu_result_c),
        .illegal_c (alu_illegal_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            enable_q <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            enable_q <= enable_d;
            clear_q  <= clear_d;
            done_q   <= done_d;
            erro_q   <= erro_d;
        end
    end

    // Next state; strobes computed in EXEC so they are registered high in WRITE
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        result_d = result_q;
        ready_d  = 1'b0;
        enable_d = 1'b0;
        clear_d  = 1'b0;
        done_d   = 1'b0;
        erro_d   = erro_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (instr_valid && ready_q) begin
                    instr_d = instr_t'(instr);
                    state_d = S_DECODE;
                    ready_d = 1'b0;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Operands are sampled here, before any write to rd in WRITE
                result_d = alu_result_c;
                enable_d = !alu_illegal_c && (instr_q.op != OP_CLEAR);
                clear_d  = !alu_illegal_c && (instr_q.op == OP_CLEAR);
                erro_d   = erro_q || alu_illegal_c;
                done_d   = 1'b1;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign instr_ready      = ready_q;
    assign endereco_reg1    = instr_q.rs1;
    assign endereco_reg2    = instr_q.rs2;
    assign endereco_escrita = instr_q.rd;
    assign conteudo_escrita = result_q;
    assign enable           = enable_q;
    assign ativar_clear     = clear_q;
    assign done             = done_q;
    assign erro             = erro_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle paired with a behavioural 16x16 register bank.
// Directed sequences plus random instructions are checked against a reference
// register file and an arithmetic model of each opcode.
module tb_unidade_controle;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  endereco_reg1;
    logic [3:0]  endereco_reg2;
    logic [15:0] conteudo_reg1;
    logic [15:0] conteudo_reg2;
    logic [3:0]  endereco_escrita;
    logic [15:0] conteudo_escrita;
    logic        enable;
    logic        ativar_clear;
    logic        done;
    logic        erro;

    int n_chk  = 0;
    int n_pass = 0;

    // Register bank: async read, write/clear on the rising edge
    logic [15:0] bank [16];
    logic [15:0] ref_regs [16];
    logic        erro_exp;

    initial for (int i = 0; i < 16; i++) bank[i] = 16'h0;

    always @(posedge clk) begin
        if (ativar_clear) begin
            for (int i = 0; i < 16; i++) bank[i] <= 16'h0;
        end else if (enable) begin
            bank[endereco_escrita] <= conteudo_escrita;
        end
    end

    assign conteudo_reg1 = bank[endereco_reg1];
    assign conteudo_reg2 = bank[endereco_reg2];

    unidade_controle dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_ready      (instr_ready),
        .endereco_reg1    (endereco_reg1),
        .endereco_reg2    (endereco_reg2),
        .conteudo_reg1    (conteudo_reg1),
        .conteudo_reg2    (conteudo_reg2),
        .endereco_escrita (endereco_escrita),
        .conteudo_escrita (conteudo_escrita),
        .enable           (enable),
        .ativar_clear     (ativar_clear),
        .done             (done),
        .erro             (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference semantics; returns legality and the 16-bit value (unused for CLEAR)
    function automatic void model(input int op, input longint a, input longint b,
                                  input longint imm8, output bit legal, output longint v);
        longint imm4 = imm8 % 16;
        longint m = 65536;
        legal = 1;
        v = 0;
        case (op)
            0:  v = imm8;
            1:  v = (a + b) % m;
            2:  v = (a + imm4) % m;
            3:  v = (a - b + m) % m;
            4:  v = (a - imm4 + m) % m;
`ifdef CTRL_MUL_EN
            5:  v = (a * b) % m;
`else
            5:  legal = 0;
`endif
            6:  v = a & b;
            7:  v = a | b;
            8:  v = a ^ b;
            9:  v = (m - 1) - a;
            10: v = (a * (longint'(1) << imm4)) % m;
            11: v = a / (longint'(1) << imm4);
            15: v = 0;
            default: legal = 0;
        endcase
    endfunction

    function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2);
        return {4'(op), 4'(rd), 4'(rs1), 4'(rs2)};
    endfunction

    // Issue one instruction and check handshake, latency, strobes and the bank afterwards
    task automatic run_instr(input logic [15:0] ins);
        int     op  = int'(ins[15:12]);
        int     rd  = int'(ins[11:8]);
        int     rs1 = int'(ins[7:4]);
        int     rs2 = int'(ins[3:0]);
        bit     legal;
        longint v;
        int     n;
        model(op, longint'(ref_regs[rs1]), longint'(ref_regs[rs2]), longint'(ins[7:0]), legal, v);

        n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("ready_busy", 32'(instr_ready), 32'd0);
                check("rd_addr_a", 32'(endereco_reg1), 32'(rs1));
                check("rd_addr_b", 32'(endereco_reg2), 32'(rs2));
            end
            // Junk while busy must be ignored; drop valid once retiring
            instr = 16'($urandom);
            instr_valid = !done;
        end while (!done && n < 8);
        instr_valid = 1'b0;
        check("done_latency", 32'(n), 32'd3);
        check("enable", 32'(enable), 32'(legal && op != 15));
        check("clear", 32'(ativar_clear), 32'(legal && op == 15));
        if (!legal) erro_exp = 1'b1;
        check("erro", 32'(erro), 32'(erro_exp));
        check("wr_addr", 32'(endereco_escrita), 32'(rd));
        if (legal && op != 15) check("wr_data", 32'(conteudo_escrita), 32'(v));

        if (legal && op == 15) begin
            for (int i = 0; i < 16; i++) ref_regs[i] = 16'h0;
        end else if (legal) begin
            ref_regs[rd] = 16'(v);
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("enable_pulse", 32'(enable), 32'd0);
        check("ready_after", 32'(instr_ready), 32'd1);
        if (legal && op == 15) begin
            for (int i = 0; i < 16; i++) check("bank_cleared", 32'(bank[i]), 32'd0);
        end else begin
            check("bank_rd", 32'(bank[rd]), 32'(ref_regs[rd]));
        end
    endtask

    initial begin
        int op_r;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0;
        erro_exp = 1'b0;
        for (int i = 0; i < 16; i++) ref_regs[i] = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_clear", 32'(ativar_clear), 32'd0);
        check("rst_erro", 32'(erro), 32'd0);
        check("rst_wdata", 32'(conteudo_escrita), 32'd0);
        check("rst_addr", 32'({endereco_reg1, endereco_reg2, endereco_escrita}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed sequences
        run_instr(mk(0, 1, 0, 5));          // LOAD r1,0x05
        run_instr(mk(0, 2, 0, 3));          // LOAD r2,0x03
        run_instr(mk(1, 3, 1, 2));          // ADD r3,r1,r2 -> 8
        check("r3_add", 32'(bank[3]), 32'h0008);
        run_instr(mk(0, 4, 15, 15));        // LOAD r4,0xFF
        run_instr(mk(10, 4, 4, 8));         // SLL r4,r4,#8
        run_instr(mk(2, 4, 4, 15));         // ADDI r4,r4,#F
        check("r4_ff0f", 32'(bank[4]), 32'hFF0F);
        run_instr(mk(2, 4, 4, 1));          // ADDI r4,r4,#1
        check("r4_ff10", 32'(bank[4]), 32'hFF10);
        run_instr(mk(3, 5, 0, 1));          // SUB r5,r0,r1 -> wrap
        check("r5_wrap", 32'(bank[5]), 32'hFFFB);
        run_instr(mk(5, 6, 1, 2));          // MUL r6,r1,r2
`ifdef CTRL_MUL_EN
        check("r6_mul", 32'(bank[6]), 32'h000F);
`else
        check("r6_nomul", 32'(bank[6]), 32'h0000);
`endif
        run_instr(mk(1, 1, 1, 1));          // ADD r1,r1,r1
        check("r1_dbl", 32'(bank[1]), 32'h000A);
        run_instr(mk(12, 7, 1, 2));         // illegal
        check("erro_sticky", 32'(erro), 32'd1);
        run_instr(mk(9, 8, 5, 0));          // NOT r8,r5 still executes
        check("r8_not", 32'(bank[8]), 32'h0004);
        run_instr(mk(11, 9, 4, 4));         // SRL
        run_instr(mk(15, 0, 0, 0));         // CLEAR

        // Random instructions
        for (int k = 0; k < 60; k++) begin
            op_r = (k % 3 == 0) ? 0 : int'($urandom_range(0, 15));
            if (op_r == 15 && ($urandom_range(0, 3) != 0)) op_r = 1;
            run_instr(mk(op_r, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15))));
        end

        // Reset during EXEC: no write, back to IDLE, bank untouched
        run_instr(mk(0, 10, 3, 4));         // LOAD r10,0x34
        instr_valid = 1'b1;
        instr = mk(0, 10, 9, 9);            // LOAD r10,0x99 (aborted)
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);                     // now in EXEC
        rst_n = 1'b0;
        erro_exp = 1'b0;
        #1;
        check("abort_ready", 32'(instr_ready), 32'd1);
        check("abort_erro", 32'(erro), 32'd0);
        @(negedge clk);
        check("abort_enable", 32'(enable), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_bank", 32'(bank[10]), 32'h0034);
        rst_n = 1'b1;
        @(negedge clk);
        run_instr(mk(7, 11, 10, 10));       // OR after reset
        check("after_abort", 32'(bank[11]), 32'h0034);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
